// File: rtl/pb_event_arbiter_pkg.sv
// Shared definitions for the push-button event arbiter slice.
// Holds the arbiter FSM state encodings and the default debounce
// timing values used by every button consumer on the board.
// No ports: imported with "import pb_event_arbiter_pkg::*;".
package pb_event_arbiter_pkg;

    // Default debounce history depth and sample-tick divider
    // (1 ms per sample at a 100 MHz system clock).
    localparam int PB_DEF_SAMPLES  = 10;
    localparam int PB_DEF_TICK_DIV = 100000;

    // Arbiter FSM encodings, kept as plain constants so older blocks that
    // compare against raw bit patterns continue to work.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/pb_debounce_cell.sv
// One button's debounce path: 2-flop synchronizer, sample history,
// debounced level and a single-cycle rising-edge pulse.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   btn_in     raw asynchronous button input (1 = pressed)
//   tick       sample enable, one clk wide
//   btn_level  debounced level
//   rise       one-clk pulse, one cycle after the tick that raises btn_level
module pb_debounce_cell
    import pb_event_arbiter_pkg::*;
#(
    parameter int SAMPLES = PB_DEF_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic tick,
    output logic btn_level,
    output logic rise
);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [SAMPLES-1:0] hist_q,  hist_d;
    logic               level_q, level_d;
    logic               rise_q,  rise_d;

    // The level and the edge both use the history as it was before this
    // tick's shift, so the level lags a full window of clean samples.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        hist_d  = hist_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (tick) begin
            hist_d  = {hist_q[SAMPLES-2:0], sync2_q};
            level_d = &hist_q;
            rise_d  = (&hist_q) & ~level_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign btn_level = level_q;
    assign rise      = rise_q;

endmodule

// File: rtl/pb_event_arbiter.sv
// Debounces NUM_BTN push-buttons, latches each debounced press as a
// pending flag and offers the pending presses round-robin to a single
// consumer over a valid/ready handshake.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   btn_in     raw button inputs, 1 = pressed
//   evt_ready  consumer accepts the offered event
//   ovr_clr    one-cycle pulse clearing all overrun flags
//   evt_valid  an event is offered on evt_id
//   evt_id     index of the button whose press is offered
//   btn_level  debounced button levels
//   overrun    sticky: a press was lost because one was already pending
module pb_event_arbiter
    import pb_event_arbiter_pkg::*;
#(
    parameter int NUM_BTN  = 4,
    parameter int SAMPLES  = PB_DEF_SAMPLES,
    parameter int TICK_DIV = PB_DEF_TICK_DIV,
    localparam int IDW     = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               evt_ready,
    input  logic               ovr_clr,
    output logic               evt_valid,
    output logic [IDW-1:0]     evt_id,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] overrun
);

    localparam int             CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tick;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] overrun_q, overrun_d;
    logic [NUM_BTN-1:0] clr_vec;
    logic [NUM_BTN-1:0] ovr_set;
    logic [0:0]         state_q, state_d;
    logic               evt_valid_q, evt_valid_d;
    logic [IDW-1:0]     evt_id_q, evt_id_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     pick;
    logic               handshake;

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        pb_debounce_cell #(
            .SAMPLES (SAMPLES)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[i]),
            .tick      (tick),
            .btn_level (btn_level[i]),
            .rise      (rise[i])
        );
    end

    assign handshake = (state_q == ST_OFFER) && evt_valid_q && evt_ready;

    // A same-cycle rise re-arms the flag being cleared, so a press that
    // lands exactly on the handshake is kept rather than counted as lost.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            clr_vec[i] = handshake && (evt_id_q == IDW'(i));
        end
        ovr_set   = rise & pending_q & ~clr_vec;
        pending_d = (pending_q & ~clr_vec) | rise;
        overrun_d = ovr_clr ? ovr_set : (overrun_q | ovr_set);
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_BTN;
            if (!found && pending_q[IDW'(idx)]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    // The offer is captured on entry to OFFER and frozen until accepted;
    // returning through IDLE guarantees a low cycle between events.
    always_comb begin
        state_d      = state_q;
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    evt_id_d    = pick;
                    evt_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    evt_valid_d  = 1'b0;
                    last_grant_d = evt_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            state_q      <= ST_IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= IDW'(NUM_BTN - 1);
        end else begin
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter (NUM_BTN=4, SAMPLES=10,
// TICK_DIV=4). Expected event ids are queued when a press is issued;
// a negedge monitor pops and compares on every accepted event.
module tb_pb_event_arbiter;

    localparam int NUM_BTN  = 4;
    localparam int SAMPLES  = 10;
    localparam int TICK_DIV = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_BTN-1:0] btn_in = '0;
    logic               evt_ready = 1'b1;
    logic               ovr_clr = 1'b0;
    logic               evt_valid;
    logic [1:0]         evt_id;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] overrun;

    int passed = 0;
    int total  = 0;
    int exp_q[$];
    int exp_id;
    logic prev_hs = 1'b0;

    pb_event_arbiter #(
        .NUM_BTN  (NUM_BTN),
        .SAMPLES  (SAMPLES),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .evt_ready (evt_ready),
        .ovr_clr   (ovr_clr),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .btn_level (btn_level),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic reportFail(input string name);
        total++;
        $display("[TB] FAIL %s: got timeout, expected event within budget", name);
    endtask

    // Inputs change 2 time units after a rising edge, well away from the
    // negedge where outputs are sampled.
    task automatic stepClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_BTN-1:0] btn, input logic rdy);
        btn_in    = btn;
        evt_ready = rdy;
    endtask

    task automatic doReset();
        rst = 1'b0;
        stepClk(2);
        rst = 1'b1;
        stepClk(2);
    endtask

    task automatic waitValid(input int max, input string name);
        int n = 0;
        while (!evt_valid && n < max) begin
            stepClk(1);
            n++;
        end
        if (!evt_valid) reportFail(name);
    endtask

    task automatic waitLevel(input int idx, input logic v, input int max, input string name);
        int n = 0;
        while (btn_level[idx] !== v && n < max) begin
            stepClk(1);
            n++;
        end
        if (btn_level[idx] !== v) reportFail(name);
    endtask

    task automatic waitDrain(input int max, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            stepClk(1);
            n++;
        end
        if (exp_q.size() != 0) reportFail(name);
    endtask

    // Monitor: every accepted event must match the head of the queue, and
    // the cycle after an accepted event must show evt_valid low.
    always @(negedge clk) begin
        if (!rst) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) checkOutput("valid_gap", {31'b0, evt_valid}, 32'd0);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("[TB] FAIL unexpected_event: got id %0d, expected no event", evt_id);
                end else begin
                    exp_id = exp_q.pop_front();
                    checkOutput("event_id", {30'b0, evt_id}, exp_id);
                end
                prev_hs = 1'b1;
            end else begin
                prev_hs = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        stepClk(3);
        checkOutput("rst_valid",   {31'b0, evt_valid}, 32'd0);
        checkOutput("rst_level",   {28'b0, btn_level}, 32'd0);
        checkOutput("rst_overrun", {28'b0, overrun},   32'd0);
        checkOutput("rst_id",      {30'b0, evt_id},    32'd0);
        rst = 1'b1;
        stepClk(2);

        // 1: clean press of button 0, held without repeat events
        exp_q.push_back(0);
        applyStimulus(4'b0001, 1'b1);
        waitDrain(60, "t1_event");
        stepClk(2);
        checkOutput("t1_level", {28'b0, btn_level}, 32'h1);
        stepClk(100);
        checkOutput("t1_no_repeat", {31'b0, evt_valid}, 32'd0);
        applyStimulus(4'b0000, 1'b1);
        waitLevel(0, 1'b0, 40, "t1_release");

        // 2: bouncing button 1 never debounces
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
            stepClk(12);
            checkOutput("t2_level", {31'b0, btn_level[1]}, 32'd0);
        end
        applyStimulus(4'b0000, 1'b1);
        stepClk(60);
        checkOutput("t2_level_end", {28'b0, btn_level}, 32'd0);

        // 3: simultaneous presses 0,2,3 from a fresh round-robin pointer
        doReset();
        exp_q.push_back(0);
        exp_q.push_back(2);
        exp_q.push_back(3);
        applyStimulus(4'b1101, 1'b1);
        waitDrain(80, "t3_events");
        stepClk(5);
        checkOutput("t3_idle",  {31'b0, evt_valid}, 32'd0);
        checkOutput("t3_level", {28'b0, btn_level}, 32'hD);
        applyStimulus(4'b0000, 1'b1);
        stepClk(30);
        checkOutput("t3_release", {28'b0, btn_level}, 32'd0);

        // 4: backpressure on id 0, second press is lost as overrun
        doReset();
        exp_q.push_back(0);
        applyStimulus(4'b0001, 1'b0);
        waitValid(60, "t4_offer");
        checkOutput("t4_id", {30'b0, evt_id}, 32'd0);
        applyStimulus(4'b0000, 1'b0);
        stepClk(30);
        checkOutput("t4_released", {31'b0, btn_level[0]}, 32'd0);
        applyStimulus(4'b0001, 1'b0);
        waitLevel(0, 1'b1, 60, "t4_repress");
        stepClk(3);
        checkOutput("t4_overrun", {28'b0, overrun}, 32'h1);
        checkOutput("t4_valid",   {31'b0, evt_valid}, 32'd1);
        checkOutput("t4_id_hold", {30'b0, evt_id}, 32'd0);
        applyStimulus(4'b0001, 1'b1);
        waitDrain(10, "t4_accept");
        stepClk(20);
        checkOutput("t4_single",  {31'b0, evt_valid}, 32'd0);
        checkOutput("t4_pending", {28'b0, dut.pending_q}, 32'd0);
        checkOutput("t4_sticky",  {28'b0, overrun}, 32'h1);
        ovr_clr = 1'b1;
        stepClk(1);
        ovr_clr = 1'b0;
        checkOutput("t4_ovr_clr", {28'b0, overrun}, 32'd0);

        // 5: asynchronous reset while an event is on offer
        applyStimulus(4'b0000, 1'b1);
        stepClk(30);
        applyStimulus(4'b0010, 1'b0);
        waitValid(60, "t5_offer");
        checkOutput("t5_id", {30'b0, evt_id}, 32'd1);
        applyStimulus(4'b0000, 1'b0);
        stepClk(30);
        applyStimulus(4'b0010, 1'b0);
        waitLevel(1, 1'b1, 60, "t5_repress");
        stepClk(3);
        checkOutput("t5_overrun", {28'b0, overrun}, 32'h2);
        applyStimulus(4'b0000, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_valid",   {31'b0, evt_valid}, 32'd0);
        checkOutput("t5_rst_pending", {28'b0, dut.pending_q}, 32'd0);
        checkOutput("t5_rst_overrun", {28'b0, overrun}, 32'd0);
        checkOutput("t5_rst_level",   {28'b0, btn_level}, 32'd0);
        stepClk(2);
        rst = 1'b1;
        evt_ready = 1'b1;
        stepClk(60);
        checkOutput("t5_quiet", {31'b0, evt_valid}, 32'd0);
        exp_q.push_back(1);
        applyStimulus(4'b0010, 1'b1);
        waitDrain(80, "t5_new_press");
        stepClk(5);
        applyStimulus(4'b0000, 1'b1);
        stepClk(10);

        checkOutput("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
